aes_block_serializer: RTL

- Parametrised successor to the AES-256 output loading stage.
- Buffers up to DEPTH completed 128-bit ciphertext blocks from the encryption core in a block FIFO.
- Streams each buffered block out as 128/OUT_W beats of OUT_W bits, most significant beat first, on a request/ready handshake.
- Sits between the encryption top (enc_done/data) and the external consumer, which is driven by the TB interface's next_val_req.

---
 rtl/aes_block_serializer.sv | 131 +++++++++++++
 1 files changed

// File: rtl/aes_block_serializer.sv
// Buffers completed AES ciphertext blocks in a small FIFO and streams each one out MSB-first in OUT_W-bit beats.
// Optional synchronous flush input is enabled with the AES_SER_FLUSH_EN macro.
module aes_block_serializer #(
    parameter int OUT_W = 8,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
`ifdef AES_SER_FLUSH_EN
    input  logic                       pi_flush,
`endif
    input  logic                       pi_enc_done,
    input  logic [127:0]               pi_block,
    input  logic                       pi_next_val_req,
    output logic                       po_next_val_ready,
    output logic [OUT_W-1:0]           po_data,
    output logic                       po_last,
    output logic                       po_full,
    output logic [$clog2(DEPTH+1)-1:0] po_level,
    output logic                       po_overflow
);

    localparam int BEATS = 128 / OUT_W;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LVL_W = $clog2(DEPTH + 1);

    if (!(OUT_W == 8 || OUT_W == 16 || OUT_W == 32 || OUT_W == 64 || OUT_W == 128)) begin : g_bad_out_w
        $error("aes_block_serializer: OUT_W must be 8, 16, 32, 64 or 128");
    end
    if (DEPTH < 1 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("aes_block_serializer: DEPTH must be a power of 2 between 1 and 16");
    end

    typedef enum logic {EMPTY, ACTIVE} state_t;

    state_t             state_q;
    logic [127:0]       mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]   level_q, level_d;
    logic [CNT_W-1:0]   beat_cnt_q;
    logic [OUT_W-1:0]   data_q;
    logic               ready_q, last_q, overflow_q;

    logic               flush, last_beat, issue, pop, full, push, drop;
    logic [127:0]       head_shift;

`ifdef AES_SER_FLUSH_EN
    assign flush = pi_flush;
`else
    assign flush = 1'b0;
`endif

    // A beat is only issued from a non-empty FIFO; flush suppresses it and any same-cycle write.
    assign last_beat  = (beat_cnt_q == CNT_W'(BEATS - 1));
    assign issue      = (state_q == ACTIVE) && pi_next_val_req && !flush;
    assign pop        = issue && last_beat;
    assign full       = (level_q == LVL_W'(DEPTH));
    assign push       = pi_enc_done && !flush && (!full || pop);
    assign drop       = pi_enc_done && !flush && full && !pop;
    assign head_shift = mem_q[rd_ptr_q] << (OUT_W * int'(beat_cnt_q));

    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= pi_block;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= EMPTY;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            beat_cnt_q <= '0;
            data_q     <= '0;
            ready_q    <= 1'b0;
            last_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            ready_q <= issue;
            last_q  <= pop;
            if (issue) begin
                data_q <= head_shift[127 -: OUT_W];
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end
            if (flush) begin
                state_q    <= EMPTY;
                wr_ptr_q   <= '0;
                rd_ptr_q   <= '0;
                level_q    <= '0;
                beat_cnt_q <= '0;
            end else begin
                if (push) begin
                    wr_ptr_q <= ptr_inc(wr_ptr_q);
                end
                if (pop) begin
                    rd_ptr_q <= ptr_inc(rd_ptr_q);
                end
                if (issue) begin
                    beat_cnt_q <= last_beat ? '0 : beat_cnt_q + CNT_W'(1);
                end
                level_q <= level_d;
                state_q <= (level_d == '0) ? EMPTY : ACTIVE;
            end
        end
    end

    assign po_next_val_ready = ready_q;
    assign po_data           = data_q;
    assign po_last           = last_q;
    assign po_full           = full;
    assign po_level          = level_q;
    assign po_overflow       = overflow_q;

endmodule
